// File: rtl/mac_layer_seq.sv
// mac_layer_seq: time-multiplexed fully connected layer.
// One unsigned input element is accepted per beat and multiplied against a
// column of N_OUT signed weights; after N_IN beats the accumulators are
// shifted, passed through hard-sigmoid or ReLU, and held on a valid/ready
// output until downstream takes them.
module mac_layer_seq #(
  parameter int N_IN    = 32,
  parameter int N_OUT   = 8,
  parameter int WIDTH_W = 9,
  parameter int WIDTH_X = 8,
  parameter int WIDTH_O = 7,
  parameter int SHIFT   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             w_we,
  input  logic [$clog2(N_IN*N_OUT)-1:0]    w_addr,
  input  logic [WIDTH_W-1:0]               w_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH_X-1:0]               in_data,
  input  logic                             act_sel,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [N_OUT*WIDTH_O-1:0]         out_data,
  output logic                             busy
);

  localparam int N_W  = N_IN * N_OUT;
  localparam int AW   = $clog2(N_W);
  localparam int CW   = $clog2(N_IN);
  localparam int PW   = WIDTH_W + WIDTH_X + 1;
  localparam int ACCW = PW + CW;
  localparam int VW   = ACCW + 1;

  localparam logic signed [VW-1:0] BIAS = VW'(1 << (WIDTH_O - 1));
  localparam logic signed [VW-1:0] ZERO = '0;
  localparam logic signed [VW-1:0] OMAX = VW'((1 << WIDTH_O) - 1);

  typedef enum logic [1:0] {LOAD, ACT, HOLD} state_t;

  logic signed [WIDTH_W-1:0] w_mem_q [N_W];
  logic signed [WIDTH_W-1:0] w_mem_d [N_W];

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic signed [ACCW-1:0]    acc_q [N_OUT];
  logic signed [ACCW-1:0]    acc_d [N_OUT];
  logic                      out_valid_q, out_valid_d;
  logic [N_OUT*WIDTH_O-1:0]  out_data_q, out_data_d;

  logic                      wr_en;
  logic                      beat;
  logic signed [WIDTH_X:0]   x_ext;
  logic [AW-1:0]             w_idx;
  logic signed [WIDTH_W-1:0] w_sel;
  logic signed [ACCW-1:0]    shifted;
  logic signed [VW-1:0]      bias_sel;
  logic signed [VW-1:0]      biased;
  logic signed [PW-1:0]      prod    [N_OUT];
  logic [WIDTH_O-1:0]        act_res [N_OUT];

  // Handshake qualifiers: a pending weight write at cnt==0 blocks the beat.
  always_comb begin
    wr_en    = w_we && (state_q == LOAD) && (cnt_q == '0) && (int'(w_addr) < N_W);
    in_ready = !rst && (state_q == LOAD) && !(w_we && (cnt_q == '0));
    beat     = in_valid && in_ready;
    busy     = (cnt_q != '0) || (state_q != LOAD);
  end

  // Per-neuron product for the current beat and activation of the accumulator.
  always_comb begin
    x_ext    = {1'b0, in_data};
    bias_sel = act_sel ? ZERO : BIAS;
    w_idx    = '0;
    w_sel    = '0;
    shifted  = '0;
    biased   = '0;
    for (int unsigned o = 0; o < N_OUT; o++) begin
      w_idx   = AW'(o * N_IN) + AW'(cnt_q);
      w_sel   = w_mem_q[w_idx];
      prod[o] = PW'(w_sel) * PW'(x_ext);
      shifted = acc_q[o] >>> SHIFT;
      biased  = VW'(shifted) + bias_sel;
      if (biased < 0) begin
        act_res[o] = '0;
      end else if (biased > OMAX) begin
        act_res[o] = '1;
      end else begin
        act_res[o] = biased[WIDTH_O-1:0];
      end
    end
  end

  // Next-state logic for the weight store, frame counter, accumulators and output.
  always_comb begin
    w_mem_d     = w_mem_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (wr_en) begin
      w_mem_d[w_addr] = w_data;
    end

    case (state_q)
      LOAD: begin
        if (beat) begin
          for (int unsigned o = 0; o < N_OUT; o++) begin
            acc_d[o] = acc_q[o] + ACCW'(prod[o]);
          end
          if (cnt_q == CW'(N_IN - 1)) begin
            cnt_d   = '0;
            state_d = ACT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ACT: begin
        for (int unsigned o = 0; o < N_OUT; o++) begin
          out_data_d[o*WIDTH_O +: WIDTH_O] = act_res[o];
        end
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          acc_d       = '{default: '0};
          out_valid_d = 1'b0;
          state_d     = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Weight store is deliberately not reset so weights survive a frame abort.
  always_ff @(posedge clk) begin
    w_mem_q <= w_mem_d;
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      acc_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_mac_layer_seq.sv
// Directed self-checking bench for mac_layer_seq with default parameters.
module tb_mac_layer_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_we;
  logic [7:0]  w_addr;
  logic [8:0]  w_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        act_sel;
  logic        out_valid;
  logic        out_ready;
  logic [55:0] out_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  mac_layer_seq #(
    .N_IN(32), .N_OUT(8), .WIDTH_W(9), .WIDTH_X(8), .WIDTH_O(7), .SHIFT(8)
  ) dut (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .act_sel(act_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all(input logic [8:0] v);
    for (int i = 0; i < 256; i++) begin
      w_we = 1'b1; w_addr = 8'(i); w_data = v;
      tick();
    end
    w_we = 1'b0;
  endtask

  // Presents one element and waits (bounded) for it to be taken; in_valid stays high.
  task automatic send_beat(input logic [7:0] x);
    bit ok = 1'b0;
    int n  = 0;
    in_valid = 1'b1; in_data = x;
    while (!ok && n < 20) begin
      #1 ok = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL beat_timeout got=in_ready_low exp=accept");
    end
  endtask

  task automatic send_frame(input logic [7:0] xs [32], input bit gaps);
    for (int i = 0; i < 32; i++) begin
      if (gaps) begin
        int idle = $urandom_range(0, 2);
        in_valid = 1'b0;
        for (int k = 0; k < idle; k++) tick();
      end
      send_beat(xs[i]);
    end
    in_valid = 1'b0;
  endtask

  task automatic const_frame(input logic [7:0] x, input bit gaps);
    logic [7:0] xs [32];
    for (int i = 0; i < 32; i++) xs[i] = x;
    send_frame(xs, gaps);
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 50) begin
      tick(); n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL out_valid_timeout got=%b exp=1", out_valid);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'd1;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 56'd0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    in_valid = 1'b0; rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    logic [6:0] e;
    load_all(9'd1);
    for (int m = 0; m < 2; m++) begin
      act_sel = m[0];
      e = (m == 0) ? 7'd95 : 7'd31;
      const_frame(8'd255, 1'b0);
      wait_out();
      for (int o = 0; o < 8; o++) begin
        checks++;
        if (out_data[o*7 +: 7] !== e) begin
          failures++;
          $display("FAIL basic_sel%0d_n%0d got=%0d exp=%0d", m, o, out_data[o*7 +: 7], e);
        end
      end
      handshake();
    end
  endtask

  task automatic test_saturation();
    logic [8:0] wv;
    logic [6:0] e;
    for (int c = 0; c < 4; c++) begin
      wv = (c < 2) ? 9'h100 : 9'd255;
      e  = (c < 2) ? 7'd0 : 7'd127;
      if (c == 0 || c == 2) load_all(wv);
      act_sel = c[0];
      const_frame(8'd255, 1'b0);
      wait_out();
      for (int o = 0; o < 8; o++) begin
        checks++;
        if (out_data[o*7 +: 7] !== e) begin
          failures++;
          $display("FAIL sat_case%0d_n%0d got=%0d exp=%0d", c, o, out_data[o*7 +: 7], e);
        end
      end
      handshake();
    end
  endtask

  task automatic test_single_weight();
    logic [7:0] xs [32];
    logic [6:0] exp_n [8];
    exp_n = '{7'd64, 7'd71, 7'd79, 7'd87, 7'd95, 7'd103, 7'd110, 7'd118};
    for (int i = 0; i < 256; i++) begin
      w_we = 1'b1; w_addr = 8'(i);
      w_data = (i % 32 == 0) ? 9'(10 * (i / 32)) : 9'd0;
      tick();
    end
    w_we = 1'b0;
    act_sel = 1'b0;
    for (int i = 0; i < 32; i++) xs[i] = (i == 0) ? 8'd200 : 8'd0;
    send_frame(xs, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_act_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL lat_act_busy got=%b exp=1", busy); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_hold_out_valid got=%b exp=1", out_valid); end
    for (int o = 0; o < 8; o++) begin
      checks++;
      if (out_data[o*7 +: 7] !== exp_n[o]) begin
        failures++;
        $display("FAIL single_n%0d got=%0d exp=%0d", o, out_data[o*7 +: 7], exp_n[o]);
      end
    end
    handshake();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hs_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hs_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_stall();
    logic [55:0] e95;
    for (int o = 0; o < 8; o++) e95[o*7 +: 7] = 7'd95;
    load_all(9'd1);
    act_sel = 1'b0;
    const_frame(8'd255, 1'b1);
    wait_out();
    in_valid = 1'b1; in_data = 8'd7;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++; if (out_data !== e95) begin failures++; $display("FAIL stall_data_c%0d got=%h exp=%h", k, out_data, e95); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready_c%0d got=%b exp=0", k, in_ready); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy_c%0d got=%b exp=1", k, busy); end
      tick();
    end
    in_valid = 1'b0;
    handshake();
    const_frame(8'd0, 1'b1);
    wait_out();
    for (int o = 0; o < 8; o++) begin
      checks++;
      if (out_data[o*7 +: 7] !== 7'd64) begin
        failures++;
        $display("FAIL indep_n%0d got=%0d exp=64", o, out_data[o*7 +: 7]);
      end
    end
    handshake();
  endtask

  task automatic test_reset_midframe();
    act_sel = 1'b0;
    for (int i = 0; i < 10; i++) send_beat(8'd255);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_in_ready got=%b exp=0", in_ready); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    const_frame(8'd255, 1'b0);
    wait_out();
    for (int o = 0; o < 8; o++) begin
      checks++;
      if (out_data[o*7 +: 7] !== 7'd95) begin
        failures++;
        $display("FAIL mid_rst_n%0d got=%0d exp=95", o, out_data[o*7 +: 7]);
      end
    end
    handshake();
  endtask

  task automatic test_weight_write();
    logic [6:0] e;
    act_sel = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(8'd255);
    w_we = 1'b1; w_addr = 8'd20; w_data = 9'd100;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midwr_in_ready got=%b exp=1", in_ready); end
    send_beat(8'd255);
    w_we = 1'b0;
    for (int i = 6; i < 32; i++) send_beat(8'd255);
    in_valid = 1'b0;
    wait_out();
    for (int o = 0; o < 8; o++) begin
      checks++;
      if (out_data[o*7 +: 7] !== 7'd95) begin
        failures++;
        $display("FAIL midwr_n%0d got=%0d exp=95", o, out_data[o*7 +: 7]);
      end
    end
    handshake();
    in_valid = 1'b1; in_data = 8'd255;
    w_we = 1'b1; w_addr = 8'd0; w_data = 9'd0;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL wr_win_in_ready got=%b exp=0", in_ready); end
    tick();
    w_we = 1'b0;
    const_frame(8'd255, 1'b0);
    wait_out();
    for (int o = 0; o < 8; o++) begin
      e = (o == 0) ? 7'd94 : 7'd95;
      checks++;
      if (out_data[o*7 +: 7] !== e) begin
        failures++;
        $display("FAIL wr_win_n%0d got=%0d exp=%0d", o, out_data[o*7 +: 7], e);
      end
    end
    handshake();
  endtask

  initial begin
    rst = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0;
    in_valid = 1'b0; in_data = '0; act_sel = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_single_weight();
    test_stall();
    test_reset_midframe();
    test_weight_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
